microc_call: RTL
================

Name: microc_call

Overview:
- Second-generation single-cycle microcontroller datapath without data memory. Driven cycle by cycle by an external control unit, which decodes `opcode` and returns the control strobes.
- Generalised to a parametrised PC width, data width and return-stack depth.
- Adds subroutine call/return through a hardware return-address stack, a carry flag, and stack status/error reporting.
- Program memory is external: the datapath presents `pc` and receives `instr` combinationally in the same cycle.

Parameters:
PC_W, 10, program counter width (8..12); jump/call target = instr[PC_W-1:0]
DW, 8, data/register width (>=8); immediate = instr[11:4] zero-extended to DW
STK_DEPTH, 4, return-stack entries (power of two, 2..16)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state
instr  in  16  instruction word for address pc
pc  out  PC_W  current program counter (program memory address)
opcode  out  6  instr[15:10] to control unit
s_inc  in  1  1: next PC = pc+1; 0: next PC = target
s_inm  in  1  1: ALU A = immediate, read port 2 addr = instr[3:0]; 0: A = rd1, read port 2 addr = instr[7:4]
we3  in  1  register-file write enable
wez  in  1  flag (z, c) write enable
op  in  3  ALU operation
call  in  1  push pc+1, jump to target
ret  in  1  pop return address into PC
z  out  1  zero flag (registered)
c  out  1  carry/borrow flag (registered)
sp  out  $clog2(STK_DEPTH)+1  stack occupancy 0..STK_DEPTH
stk_full  out  1  sp==STK_DEPTH
stk_empty  out  1  sp==0
stk_err  out  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, z=0, c=0, sp=0, stk_err=0.
  - All 16 registers cleared; stack contents cleared.
  - Effective immediately, independent of clk, and overrides any in-flight call/ret.
- Register file:
  - 16 x DW. Read addresses: RA1=instr[11:8], RA2 per s_inm. Write address WA3=instr[3:0].
  - Reads are combinational. The write takes effect on the edge when we3=1; the written value is visible from the next cycle (no write-through).
  - R0 always reads 0; writes to R0 are ignored.
- ALU (combinational, DW bits): A per s_inm, B=rd2.
  - op encodings: 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B.
  - Write data wd3 = ALU result.
  - Zero next = (result==0).
  - Carry next = carry-out for 010; borrow (A<B unsigned) for 011; 0 for all other ops.
  - z and c update together on the edge only when wez=1; otherwise both hold.
- Next-PC priority (first match wins):
  1. ret=1 and sp>0: PC <= stack[sp-1]; sp decrements.
  2. ret=1 and sp==0: PC <= pc+1; stk_err <= 1; sp stays 0.
  3. call=1 and sp<STK_DEPTH: stack[sp] <= pc+1 (mod 2^PC_W); sp increments; PC <= target.
  4. call=1 and sp==STK_DEPTH: PC <= target; push dropped; stk_err <= 1; sp unchanged.
  5. Otherwise: PC <= s_inc ? pc+1 : target.
- call and ret asserted together: ret wins and call is ignored (no push).
- PC arithmetic wraps modulo 2^PC_W (max address + 1 -> 0).
- Register writes and flag updates are independent of call/ret and still occur if their strobes are asserted.
- Latency: every instruction completes in one cycle; a branch/call/ret target is on `pc` in the cycle after the strobe.
- stk_err is sticky and clears only on reset.
- stk_full and stk_empty are combinational from sp.

Test Plan:
- Reset/ALU: reset low mid-run -> pc=0, z=0, sp=0 immediately. Then s_inm=1, instr=16'h0_2A1 (imm 8'h2A, WA3=1), op=000, we3=1 -> R1=8'h2A next cycle.
- Flags: R1=8'hFF, R2=8'h01, op=010, wez=1 -> result 0, z=1, c=1. Next cycle op=011 with R1=1, R2=2, wez=0 -> z, c hold at 1, 1.
- Call/return: at pc=10'h005, call=1, target=10'h100 -> pc=10'h100, sp=1. At a later cycle ret=1 -> pc=10'h006, sp=0, stk_err=0.
- Overflow: STK_DEPTH=4, five consecutive calls -> sp saturates at 4, stk_full=1, stk_err=1, 5th jump taken. Four rets return in LIFO order to the first four return addresses.
- Underflow and simultaneous strobes: ret at sp==0 from pc=10'h020 -> pc=10'h021, stk_err=1. call=ret=1 at sp=1 -> pop only, sp=0.
- Wrap and R0: pc=10'h3FF with s_inc=1 -> pc=10'h000. A write to R0 with we3=1 -> R0 still reads 0.

Source files
------------

// File: rtl/microc_call_if.sv
// -----------------------------------------------------------------------------
// microc_call_if
// Bundles the datapath <-> control-unit / program-memory signals of microc_call.
//
//   instr     : 16-bit instruction word fetched from address pc
//   pc        : current program counter (program memory address)
//   opcode    : instr[15:10], handed to the external control unit
//   s_inc     : 1 = sequential next PC, 0 = jump to target
//   s_inm     : 1 = ALU A is the immediate, 0 = ALU A is register read port 1
//   we3, wez  : register-file and flag write enables
//   op        : ALU operation
//   call, ret : subroutine call / return strobes
//   z, c      : registered zero and carry flags
//   sp        : return-stack occupancy 0..STK_DEPTH
//   stk_full, stk_empty, stk_err : return-stack status (stk_err sticky)
//
// master : control unit / program memory side
// slave  : datapath side
// -----------------------------------------------------------------------------
interface microc_call_if #(
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 4
);
    localparam int SPW = $clog2(STK_DEPTH) + 1;

    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
    logic [5:0]      opcode;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [2:0]      op;
    logic            call;
    logic            ret;
    logic            z;
    logic            c;
    logic [SPW-1:0]  sp;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_err;

    modport master (
        output instr, s_inc, s_inm, we3, wez, op, call, ret,
        input  pc, opcode, z, c, sp, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  instr, s_inc, s_inm, we3, wez, op, call, ret,
        output pc, opcode, z, c, sp, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/microc_call.sv
// -----------------------------------------------------------------------------
// microc_call
// Single-cycle microcontroller datapath with a hardware return-address stack.
// An external control unit decodes `opcode` and drives the control strobes;
// every instruction completes in one clock.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low; clears PC, flags, registers and stack
//   bus   : microc_call_if.slave (instruction in, PC/status out, strobes in)
//
// Parameters:
//   PC_W      : program counter width; jump/call target = instr[PC_W-1:0]
//   DW        : data width; immediate = instr[11:4] zero-extended
//   STK_DEPTH : return-stack entries (power of two)
// -----------------------------------------------------------------------------
module microc_call #(
    parameter int PC_W      = 10,
    parameter int DW        = 8,
    parameter int STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    microc_call_if.slave  bus
);
    localparam int             SPW     = $clog2(STK_DEPTH) + 1;
    localparam int             IDXW    = $clog2(STK_DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STK_DEPTH);

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_NOT  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_NEGA = 3'b110,
        ALU_NEGB = 3'b111
    } alu_op_e;

    // Architectural state
    logic [PC_W-1:0] pc_q, pc_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic            stk_err_q, stk_err_d;
    logic            z_q, z_d;
    logic            c_q, c_d;
    logic [DW-1:0]   rf_q  [16];
    logic [PC_W-1:0] stk_q [STK_DEPTH];

    // Decode
    logic [3:0]      ra1, ra2, wa3;
    logic [DW-1:0]   imm, rd1, rd2;
    logic [PC_W-1:0] target, pc_inc;
    logic [IDXW-1:0] push_idx, pop_idx;
    logic            push;

    assign ra1      = bus.instr[11:8];
    assign ra2      = bus.s_inm ? bus.instr[3:0] : bus.instr[7:4];
    assign wa3      = bus.instr[3:0];
    assign imm      = DW'(bus.instr[11:4]);
    assign target   = bus.instr[PC_W-1:0];
    assign pc_inc   = pc_q + PC_W'(1);       // wraps modulo 2^PC_W
    assign push_idx = sp_q[IDXW-1:0];
    assign pop_idx  = IDXW'(sp_q - SPW'(1)); // only used when sp_q > 0

    // R0 is hard-wired to zero on both read ports
    assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
    assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

    // ALU
    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic          alu_cy;

    assign alu_a = bus.s_inm ? imm : rd1;
    assign alu_b = rd2;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        alu_y  = '0;
        alu_cy = 1'b0;
        case (alu_op_e'(bus.op))
            ALU_PASS: alu_y = alu_a;
            ALU_NOT:  alu_y = ~alu_a;
            ALU_ADD:  {alu_cy, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: begin
                alu_y  = alu_a - alu_b;
                alu_cy = (alu_a < alu_b);    // borrow
            end
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_NEGA: alu_y = '0 - alu_a;
            ALU_NEGB: alu_y = '0 - alu_b;
            default:  alu_y = '0;
        endcase
    end

    // z and c update together, only when wez is asserted
    assign z_d = bus.wez ? (alu_y == '0) : z_q;
    assign c_d = bus.wez ? alu_cy : c_q;

    // Next PC / return stack. ret takes priority over call; a simultaneous
    // call is ignored entirely (no push).
    always_comb begin
        pc_d      = bus.s_inc ? pc_inc : target;
        sp_d      = sp_q;
        stk_err_d = stk_err_q;
        push      = 1'b0;
        if (bus.ret) begin
            if (sp_q != '0) begin
                pc_d = stk_q[pop_idx];
                sp_d = sp_q - SPW'(1);
            end else begin
                pc_d      = pc_inc;          // underflow: fall through
                stk_err_d = 1'b1;
            end
        end else if (bus.call) begin
            pc_d = target;                   // jump is taken even on overflow
            if (sp_q != SP_FULL) begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
            end else begin
                stk_err_d = 1'b1;            // push dropped
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (!reset) begin
            pc_q      <= '0;
            sp_q      <= '0;
            stk_err_q <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            stk_err_q <= stk_err_d;
            z_q       <= z_d;
            c_q       <= c_d;
        end
    end

    // Register file: write visible from the next cycle, R0 never written
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: these arrays need a defined power-up state, so they are reset as flops rather than inferred as RAM.
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (bus.we3 && (wa3 != 4'd0)) begin
            rf_q[wa3] <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
        end else if (push) begin
            stk_q[push_idx] <= pc_inc;
        end
    end

    // Outputs
    assign bus.pc        = pc_q;
    assign bus.opcode    = bus.instr[15:10];
    assign bus.z         = z_q;
    assign bus.c         = c_q;
    assign bus.sp        = sp_q;
    assign bus.stk_full  = (sp_q == SP_FULL);
    assign bus.stk_empty = (sp_q == '0);
    assign bus.stk_err   = stk_err_q;

endmodule
